ps2_key_ctrl: RTL and testbench
===============================

# ps2_key_ctrl

Scancode sequencing controller between the `ps2_keyboard` receiver and the display/consumer logic of the keyboard subsystem. It drains bytes from the receiver with the `ready`/`nextdata_n` handshake and folds `E0` (extended) and `F0` (break) prefixes into single key events. It tracks Shift/Ctrl/CapsLock modifier state and a make-event counter. Events are buffered in a small queue with valid/ready backpressure. When the queue is full, the controller stalls the receiver rather than dropping bytes.

## Interface
- `EVQ_DEPTH`, 4: event queue entries; power of two, ≥2.
- `clk`  in  1  single clock, posedge.
- `rest`  in  1  asynchronous, active-high reset.
- `ps2_ready`  in  1  receiver has a byte available.
- `ps2_data`  in  8  receiver head byte, valid while `ps2_ready`=1.
- `ps2_overflow`  in  1  receiver FIFO overflow flag.
- `ps2_nextdata_n`  out  1  active-low one-cycle pop strobe to the receiver.
- `ev_valid`  out  1  queue head valid.
- `ev_ready`  in  1  consumer accepts the head (pop on `ev_valid & ev_ready`).
- `ev_code`  out  8  scancode, prefixes stripped.
- `ev_ext`  out  1  event was `E0`-prefixed.
- `ev_brk`  out  1  1 = release (break), 0 = press (make).
- `ev_mods`  out  3  {caps, ctrl, shift} snapshot after applying this event.
- `mods`  out  3  live {caps, ctrl, shift}.
- `press_cnt`  out  8  count of make events queued, wraps 255→0.
- `ovf_seen`  out  1  sticky, set when `ps2_overflow`=1, cleared only by `rest`.

## Operation
- FSM states: `S_IDLE`, `S_ACK`, `S_GAP`.
- `S_IDLE`: when `ps2_ready`=1, classify `ps2_data`:
  - `E0`: set `pend_ext`, go to `S_ACK`.
  - `F0`: set `pend_brk`, go to `S_ACK`.
  - Any other byte is final. If the queue is not full: push {code, `pend_ext`, `pend_brk`, mods'}, clear both pend flags, update modifiers, go to `S_ACK`. If the queue is full: stay in `S_IDLE` and do not acknowledge; the byte stays in the receiver.
- `S_ACK`: `ps2_nextdata_n`=0 for exactly this cycle, then go to `S_GAP`.
- `S_GAP`: one idle cycle so the receiver's `ready` reflects the pop, then go to `S_IDLE`.
- Modifiers, applied on final bytes only:
  - Shift: code `12` or `59`, ext=0. Set on make, clear on break; left and right are not distinguished.
  - Ctrl: code `14`, any ext. Set on make, clear on break.
  - Caps: code `58`, ext=0. A make with `caps_held`=0 toggles caps and sets `caps_held`. A make with `caps_held`=1 is a typematic repeat and does not toggle. A break clears `caps_held`.
- `press_cnt` increments on every pushed make event, including repeats and modifiers.
- Unknown codes are passed through unchanged. Translation to ASCII is the consumer's job.
- Queue is FWFT: `ev_*` fields are driven from the head and hold steady while `ev_valid & !ev_ready`.

## Timing
- Reset values: `ps2_nextdata_n`=1, `ev_valid`=0, `ev_code`=0, `ev_ext`=0, `ev_brk`=0, `ev_mods`=0, `mods`=0, `press_cnt`=0, `ovf_seen`=0. FSM in `S_IDLE`, pend flags, `caps_held` and queue pointers all cleared.
- Latency:
  - Byte sampled in `S_IDLE` at edge N.
  - `ev_valid` rises after edge N if the queue was empty.
  - `ps2_nextdata_n` is low from edge N to edge N+1.
  - Next sample occurs at edge N+3 at the earliest.
  - Throughput is one byte per 3 cycles.
- Full check uses the occupancy at the start of the cycle. A pop in the same cycle does not allow a push; the push happens one cycle later.
- Simultaneous push and pop on a non-full, non-empty queue leaves occupancy unchanged.
- Prefix bytes are always consumed, even when the queue is full.
- `rest` asserted mid-sequence (for example between `E0` and the final byte) discards pending prefixes. The receiver is not re-acked.

## Structure
- Package `ps2_pkg` holds:
  - Constants `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0, `SC_LSHIFT`=8'h12, `SC_RSHIFT`=8'h59, `SC_CTRL`=8'h14, `SC_CAPS`=8'h58.
  - FSM state encoding.
  - Packed event type {code[7:0], ext, brk, mods[2:0]} (13 bits).
- Sub-module `ps2_evq`: synchronous FWFT FIFO of 13-bit entries, `EVQ_DEPTH` deep, with full/empty flags.

## Test plan
- Send `1C` → one event {1C, ext0, brk0, mods 000}; `press_cnt`=1; `ps2_nextdata_n` low exactly one cycle.
- Send `1C F0 1C` → two events, the second with brk=1; `press_cnt`=1; exactly 3 `nextdata_n` pulses.
- Send `E0 14`, then `1C`, then `E0 F0 14` → events {14, ext1, brk0, mods 010}, {1C, 0, 0, 010}, {14, 1, 1, 000}; `mods` ends at 000.
- Send `58 58 F0 58 58` → caps goes 1, 1 (repeat ignored), 1, then 0; four events.
- Hold `ev_ready`=0 and send 5 make codes with `EVQ_DEPTH`=4 → 4 events queued. The 5th byte stays unacked (`nextdata_n` stays high). Raise `ev_ready` → the 5th event follows, in order.
- Send `E0`, then assert `rest` during `S_GAP`, then send `1C` → all outputs at reset values, then event {1C, ext0}. Pulse `ps2_overflow` → `ovf_seen`=1 until the next `rest`.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard scancode path.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_GAP
  } ps2_state_t;

  // mods is {caps, ctrl, shift}
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [2:0] mods;
  } ps2_event_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK);
  endfunction

endpackage

// File: rtl/ps2_evq.sv
// First-word-fall-through event queue; head reads as zero while empty.
module ps2_evq
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  ps2_event_t push_data,
  input  logic       pop,
  output ps2_event_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  ps2_event_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Drains scancode bytes from the PS/2 receiver, folds E0/F0 prefixes into
// key events, tracks modifiers and queues events for the consumer.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int EVQ_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rest,
  input  logic       ps2_ready,
  input  logic [7:0] ps2_data,
  input  logic       ps2_overflow,
  output logic       ps2_nextdata_n,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic [2:0] ev_mods,
  output logic [2:0] mods,
  output logic [7:0] press_cnt,
  output logic       ovf_seen
);

  ps2_state_t state;
  logic       pend_ext;
  logic       pend_brk;
  logic       caps_held;
  logic       caps_held_next;
  logic [2:0] mods_next;
  logic       final_byte;
  logic       push;
  logic       q_full;
  logic       q_empty;
  ps2_event_t push_ev;
  ps2_event_t head;

  assign final_byte = !is_prefix(ps2_data);
  assign push       = (state == S_IDLE) && ps2_ready && final_byte && !q_full;
  assign push_ev    = '{code: ps2_data, ext: pend_ext, brk: pend_brk, mods: mods_next};

  ps2_evq #(.DEPTH(EVQ_DEPTH)) u_evq (
    .clk       (clk),
    .rst       (rest),
    .push      (push),
    .push_data (push_ev),
    .pop       (ev_ready),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign ev_valid = !q_empty;
  assign ev_code  = head.code;
  assign ev_ext   = head.ext;
  assign ev_brk   = head.brk;
  assign ev_mods  = head.mods;

  // Modifier state as it would stand after the current byte, if it is final.
  always_comb begin
    mods_next      = mods;
    caps_held_next = caps_held;
    if (!pend_ext && (ps2_data == SC_LSHIFT || ps2_data == SC_RSHIFT))
      mods_next[0] = !pend_brk;
    if (ps2_data == SC_CTRL)
      mods_next[1] = !pend_brk;
    if (!pend_ext && ps2_data == SC_CAPS) begin
      if (pend_brk) begin
        caps_held_next = 1'b0;
      end else if (!caps_held) begin
        mods_next[2]   = !mods[2];
        caps_held_next = 1'b1;
      end
    end
  end

  // A full queue leaves a final byte unacknowledged in the receiver.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state          <= S_IDLE;
      ps2_nextdata_n <= 1'b1;
      pend_ext       <= 1'b0;
      pend_brk       <= 1'b0;
      caps_held      <= 1'b0;
      mods           <= '0;
      press_cnt      <= '0;
      ovf_seen       <= 1'b0;
    end else begin
      if (ps2_overflow) ovf_seen <= 1'b1;
      case (state)
        S_IDLE: begin
          ps2_nextdata_n <= 1'b1;
          if (ps2_ready) begin
            if (ps2_data == PS2_EXT) begin
              pend_ext       <= 1'b1;
              ps2_nextdata_n <= 1'b0;
              state          <= S_ACK;
            end else if (ps2_data == PS2_BRK) begin
              pend_brk       <= 1'b1;
              ps2_nextdata_n <= 1'b0;
              state          <= S_ACK;
            end else if (!q_full) begin
              pend_ext       <= 1'b0;
              pend_brk       <= 1'b0;
              mods           <= mods_next;
              caps_held      <= caps_held_next;
              if (!pend_brk) press_cnt <= press_cnt + 8'd1;
              ps2_nextdata_n <= 1'b0;
              state          <= S_ACK;
            end
          end
        end
        S_ACK: begin
          ps2_nextdata_n <= 1'b1;
          state          <= S_GAP;
        end
        S_GAP: begin
          ps2_nextdata_n <= 1'b1;
          state          <= S_IDLE;
        end
        default: begin
          ps2_nextdata_n <= 1'b1;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl with a behavioural receiver and consumer log.
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       rest;
  logic       ps2_ready;
  logic [7:0] ps2_data;
  logic       ps2_overflow;
  logic       ps2_nextdata_n;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;
  logic [2:0] ev_mods;
  logic [2:0] mods;
  logic [7:0] press_cnt;
  logic       ovf_seen;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int exp_press = 0;
  logic [7:0]  rx_q[$];
  logic [12:0] ev_log[$];

  ps2_key_ctrl #(.EVQ_DEPTH(4)) dut (
    .clk            (clk),
    .rest           (rest),
    .ps2_ready      (ps2_ready),
    .ps2_data       (ps2_data),
    .ps2_overflow   (ps2_overflow),
    .ps2_nextdata_n (ps2_nextdata_n),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_code        (ev_code),
    .ev_ext         (ev_ext),
    .ev_brk         (ev_brk),
    .ev_mods        (ev_mods),
    .mods           (mods),
    .press_cnt      (press_cnt),
    .ovf_seen       (ovf_seen)
  );

  always #5 clk = ~clk;

  // Receiver model pops on the ack strobe; consumer model logs accepted events.
  always @(negedge clk) begin
    if (!ps2_nextdata_n) begin
      pulses++;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
    end
    if (ev_valid && ev_ready) ev_log.push_back({ev_code, ev_ext, ev_brk, ev_mods});
    ps2_ready = (rx_q.size() != 0);
    ps2_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  end

  function automatic logic [12:0] get_ev(input int i);
    return (i < ev_log.size()) ? ev_log[i] : 13'h1FFF;
  endfunction

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      if (rx_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    @(posedge clk);
    #1;
    ev_log.delete();
    pulses = 0;
  endtask

  task automatic test_reset();
    rest = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (ps2_nextdata_n !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_nextdata_n: got %b want 1", ps2_nextdata_n); end
    vectors++; if (ev_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ev_valid: got %b want 0", ev_valid); end
    vectors++; if ({ev_code, ev_ext, ev_brk, ev_mods} !== 13'h0) begin miscompares++; $display("[TB] FAIL reset_ev_fields: got %h want 0", {ev_code, ev_ext, ev_brk, ev_mods}); end
    vectors++; if (mods !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_mods: got %b want 000", mods); end
    vectors++; if (press_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_press_cnt: got %0d want 0", press_cnt); end
    vectors++; if (ovf_seen !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf_seen: got %b want 0", ovf_seen); end
    rest = 1'b0;
    exp_press = 0;
  endtask

  task automatic test_single_make();
    bit ok;
    start_test();
    send(8'h1C);
    drain(ok);
    exp_press += 1;
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL single_timeout: got stuck want drained"); end
    vectors++; if (ev_log.size() !== 1) begin miscompares++; $display("[TB] FAIL single_count: got %0d want 1", ev_log.size()); end
    vectors++; if (get_ev(0) !== {8'h1C, 1'b0, 1'b0, 3'b000}) begin miscompares++; $display("[TB] FAIL single_event: got %h want %h", get_ev(0), {8'h1C, 5'b0}); end
    vectors++; if (press_cnt !== 8'(exp_press)) begin miscompares++; $display("[TB] FAIL single_press_cnt: got %0d want %0d", press_cnt, exp_press); end
    vectors++; if (pulses !== 1) begin miscompares++; $display("[TB] FAIL single_ack_cycles: got %0d want 1", pulses); end
  endtask

  task automatic test_break();
    bit ok;
    start_test();
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain(ok);
    exp_press += 1;
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL break_timeout: got stuck want drained"); end
    vectors++; if (ev_log.size() !== 2) begin miscompares++; $display("[TB] FAIL break_count: got %0d want 2", ev_log.size()); end
    vectors++; if (get_ev(1) !== {8'h1C, 1'b0, 1'b1, 3'b000}) begin miscompares++; $display("[TB] FAIL break_event: got %h want %h", get_ev(1), {8'h1C, 1'b0, 1'b1, 3'b000}); end
    vectors++; if (press_cnt !== 8'(exp_press)) begin miscompares++; $display("[TB] FAIL break_press_cnt: got %0d want %0d", press_cnt, exp_press); end
    vectors++; if (pulses !== 3) begin miscompares++; $display("[TB] FAIL break_ack_pulses: got %0d want 3", pulses); end
  endtask

  task automatic test_ext_ctrl();
    bit ok;
    start_test();
    send(8'hE0); send(8'h14); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h14);
    drain(ok);
    exp_press += 2;
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL ext_timeout: got stuck want drained"); end
    vectors++; if (ev_log.size() !== 3) begin miscompares++; $display("[TB] FAIL ext_count: got %0d want 3", ev_log.size()); end
    vectors++; if (get_ev(0) !== {8'h14, 1'b1, 1'b0, 3'b010}) begin miscompares++; $display("[TB] FAIL ext_ctrl_make: got %h want %h", get_ev(0), {8'h14, 1'b1, 1'b0, 3'b010}); end
    vectors++; if (get_ev(1) !== {8'h1C, 1'b0, 1'b0, 3'b010}) begin miscompares++; $display("[TB] FAIL ext_key_with_ctrl: got %h want %h", get_ev(1), {8'h1C, 1'b0, 1'b0, 3'b010}); end
    vectors++; if (get_ev(2) !== {8'h14, 1'b1, 1'b1, 3'b000}) begin miscompares++; $display("[TB] FAIL ext_ctrl_break: got %h want %h", get_ev(2), {8'h14, 1'b1, 1'b1, 3'b000}); end
    vectors++; if (mods !== 3'b000) begin miscompares++; $display("[TB] FAIL ext_mods_end: got %b want 000", mods); end
    vectors++; if (press_cnt !== 8'(exp_press)) begin miscompares++; $display("[TB] FAIL ext_press_cnt: got %0d want %0d", press_cnt, exp_press); end
  endtask

  task automatic test_caps();
    bit ok;
    start_test();
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58); send(8'h58);
    drain(ok);
    exp_press += 3;
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL caps_timeout: got stuck want drained"); end
    vectors++; if (ev_log.size() !== 4) begin miscompares++; $display("[TB] FAIL caps_count: got %0d want 4", ev_log.size()); end
    vectors++; if (get_ev(0) !== {8'h58, 1'b0, 1'b0, 3'b100}) begin miscompares++; $display("[TB] FAIL caps_toggle_on: got %h want %h", get_ev(0), {8'h58, 1'b0, 1'b0, 3'b100}); end
    vectors++; if (get_ev(1) !== {8'h58, 1'b0, 1'b0, 3'b100}) begin miscompares++; $display("[TB] FAIL caps_repeat: got %h want %h", get_ev(1), {8'h58, 1'b0, 1'b0, 3'b100}); end
    vectors++; if (get_ev(2) !== {8'h58, 1'b0, 1'b1, 3'b100}) begin miscompares++; $display("[TB] FAIL caps_break: got %h want %h", get_ev(2), {8'h58, 1'b0, 1'b1, 3'b100}); end
    vectors++; if (get_ev(3) !== {8'h58, 1'b0, 1'b0, 3'b000}) begin miscompares++; $display("[TB] FAIL caps_toggle_off: got %h want %h", get_ev(3), {8'h58, 1'b0, 1'b0, 3'b000}); end
    vectors++; if (press_cnt !== 8'(exp_press)) begin miscompares++; $display("[TB] FAIL caps_press_cnt: got %0d want %0d", press_cnt, exp_press); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] codes [5];
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h2B};
    start_test();
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(codes[i]);
    repeat (40) @(posedge clk);
    #1;
    vectors++; if (rx_q.size() !== 1) begin miscompares++; $display("[TB] FAIL full_fifth_unacked: got %0d left want 1", rx_q.size()); end
    vectors++; if (pulses !== 4) begin miscompares++; $display("[TB] FAIL full_ack_pulses: got %0d want 4", pulses); end
    vectors++; if (ps2_nextdata_n !== 1'b1) begin miscompares++; $display("[TB] FAIL full_nextdata_n: got %b want 1", ps2_nextdata_n); end
    vectors++; if ({ev_valid, ev_code} !== {1'b1, 8'h1C}) begin miscompares++; $display("[TB] FAIL full_head_hold: got %h want %h", {ev_valid, ev_code}, {1'b1, 8'h1C}); end
    vectors++; if (press_cnt !== 8'(exp_press + 4)) begin miscompares++; $display("[TB] FAIL full_press_cnt: got %0d want %0d", press_cnt, exp_press + 4); end
    ev_ready = 1'b1;
    drain(ok);
    exp_press += 5;
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL full_timeout: got stuck want drained"); end
    vectors++; if (ev_log.size() !== 5) begin miscompares++; $display("[TB] FAIL full_count: got %0d want 5", ev_log.size()); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (get_ev(i) !== {codes[i], 5'b00000}) begin
        miscompares++;
        $display("[TB] FAIL full_order[%0d]: got %h want %h", i, get_ev(i), {codes[i], 5'b00000});
      end
    end
    vectors++; if (press_cnt !== 8'(exp_press)) begin miscompares++; $display("[TB] FAIL full_press_end: got %0d want %0d", press_cnt, exp_press); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    seen = 1'b0;
    start_test();
    send(8'hE0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!ps2_nextdata_n) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++; if (!seen) begin miscompares++; $display("[TB] FAIL mid_prefix_ack: got no ack want ack"); end
    @(posedge clk);
    #1;
    rest = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if ({ps2_nextdata_n, ev_valid, mods, press_cnt, ovf_seen} !== {1'b1, 1'b0, 3'b000, 8'd0, 1'b0}) begin miscompares++; $display("[TB] FAIL mid_reset_values: got %h want %h", {ps2_nextdata_n, ev_valid, mods, press_cnt, ovf_seen}, {1'b1, 1'b0, 3'b000, 8'd0, 1'b0}); end
    rest = 1'b0;
    exp_press = 0;
    ev_log.delete();
    pulses = 0;
    send(8'h1C);
    drain(ok);
    exp_press += 1;
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL mid_timeout: got stuck want drained"); end
    vectors++; if (pulses !== 1) begin miscompares++; $display("[TB] FAIL mid_no_reack: got %0d pulses want 1", pulses); end
    vectors++; if (ev_log.size() !== 1) begin miscompares++; $display("[TB] FAIL mid_count: got %0d want 1", ev_log.size()); end
    vectors++; if (get_ev(0) !== {8'h1C, 1'b0, 1'b0, 3'b000}) begin miscompares++; $display("[TB] FAIL mid_prefix_dropped: got %h want %h", get_ev(0), {8'h1C, 5'b0}); end
    vectors++; if (press_cnt !== 8'(exp_press)) begin miscompares++; $display("[TB] FAIL mid_press_cnt: got %0d want %0d", press_cnt, exp_press); end
  endtask

  task automatic test_overflow();
    start_test();
    ps2_overflow = 1'b1;
    @(posedge clk);
    #1;
    ps2_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (ovf_seen !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_sticky: got %b want 1", ovf_seen); end
    rest = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (ovf_seen !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_cleared: got %b want 0", ovf_seen); end
    rest = 1'b0;
  endtask

  initial begin
    rest         = 1'b1;
    ps2_overflow = 1'b0;
    ev_ready     = 1'b1;
    ps2_ready    = 1'b0;
    ps2_data     = 8'h00;
    repeat (2) @(posedge clk);
    test_reset();
    test_single_make();
    test_break();
    test_ext_ctrl();
    test_caps();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
